// File: rtl/dual_port_mem_responder_pkg.sv
// Shared types for the split imem/dmem memory responder.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: per-port FSM state enum, latched request structs, byte-lane mask helper.
package dual_port_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_port_state_t;

  localparam int CNT_W = 4;

  // Request fields captured at accept time on the instruction port.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
  } imem_req_t;

  // Request fields captured at accept time on the data port.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  // Expand a 4-bit byte-lane mask to a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/dual_port_mem_responder_mem_port_fsm.sv
// One request port of the memory responder: accept, count down, pulse resp.
// Latency: resp asserted exactly LAT cycles after the accept cycle.
// Backpressure: requests are ignored outside IDLE; the requester holds until resp.
// Ports: clk, rst (sync, active-low), i_req (request present), i_pay (request fields),
//        o_accept (request taken this cycle), o_resp (response cycle), o_pay (latched fields).
module mem_port_fsm
  import dual_port_mem_responder_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int PAY_W = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [PAY_W-1:0] i_pay,
  output logic             o_accept,
  output logic             o_resp,
  output logic [PAY_W-1:0] o_pay
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  mem_port_state_t  r_state;
  mem_port_state_t  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PAY_W-1:0] r_pay;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pay   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (o_accept) begin
        r_pay <= i_pay;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_accept    = 1'b0;
    o_resp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          o_accept    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // cnt==1 here means the next cycle is the LAT-th after accept.
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == 1) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        o_resp      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_pay = r_pay;

endmodule

// File: rtl/dual_port_mem_responder.sv
// Memory-side responder for the core's split imem/dmem ports, backed by one shared word array.
// Latency: imem_resp LAT_I cycles after accept, dmem_resp LAT_D cycles after accept.
// Backpressure: each port serves one request at a time; requests are ignored while busy.
// Ports: clk, rst (sync, active-low); imem_addr/imem_rmask in, imem_rdata/imem_resp out;
//        dmem_addr/dmem_rmask/dmem_wmask/dmem_wdata in, dmem_rdata/dmem_resp out; err (sticky).
module dual_port_mem_responder
  import dual_port_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h1ECEB000,
  parameter int          LAT_I       = 2,
  parameter int          LAT_D       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Not reset: contents survive rst.
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        r_err;

  imem_req_t   w_i_req_in;
  imem_req_t   w_i_req;
  dmem_req_t   w_d_req_in;
  dmem_req_t   w_d_req;
  logic        w_i_accept_unused;
  logic        w_d_accept;
  logic        w_i_resp;
  logic        w_d_resp;
  logic [IDX_W-1:0] w_i_idx;
  logic [IDX_W-1:0] w_d_idx;
  logic [31:0] w_d_wbits;

  assign w_i_req_in = '{addr: imem_addr, rmask: imem_rmask};
  assign w_d_req_in = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

  mem_port_fsm #(.LAT(LAT_I), .PAY_W($bits(imem_req_t))) u_i_port (
    .clk      (clk),
    .rst      (rst),
    .i_req    (|imem_rmask),
    .i_pay    (w_i_req_in),
    .o_accept (w_i_accept_unused),
    .o_resp   (w_i_resp),
    .o_pay    (w_i_req)
  );

  mem_port_fsm #(.LAT(LAT_D), .PAY_W($bits(dmem_req_t))) u_d_port (
    .clk      (clk),
    .rst      (rst),
    .i_req    ((|dmem_rmask) | (|dmem_wmask)),
    .i_pay    (w_d_req_in),
    .o_accept (w_d_accept),
    .o_resp   (w_d_resp),
    .o_pay    (w_d_req)
  );

  // Offset from base, drop byte bits, wrap modulo the array size.
  assign w_i_idx = IDX_W'((w_i_req.addr - ADDR_BASE) >> 2);
  assign w_d_idx = IDX_W'((w_d_req.addr - ADDR_BASE) >> 2);

  // Combinational read in the RESP cycle sees the array before this cycle's write lands.
  assign imem_resp  = w_i_resp;
  assign imem_rdata = w_i_resp ? (r_mem[w_i_idx] & lane_mask(w_i_req.rmask)) : '0;

  assign dmem_resp  = w_d_resp;
  // A combined read+write request returns zero data.
  assign dmem_rdata = (w_d_resp && (w_d_req.wmask == 4'b0000))
                    ? (r_mem[w_d_idx] & lane_mask(w_d_req.rmask)) : '0;

  assign w_d_wbits = lane_mask(w_d_req.wmask);

  // Write commits at the edge closing the D RESP cycle, unless that edge is a reset.
  always_ff @(posedge clk) begin
    if (rst && w_d_resp) begin
      r_mem[w_d_idx] <= (r_mem[w_d_idx] & ~w_d_wbits) | (w_d_req.wdata & w_d_wbits);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_d_accept && (|dmem_rmask) && (|dmem_wmask)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench: transaction-level model of both ports plus directed literal checks.
// Latency: n/a.
// Backpressure: requests are held until the matching resp is observed.
module tb_dual_port_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1ECEB000;
  localparam int          LI    = 2;
  localparam int          LD    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        err;

  always #5 clk = ~clk;

  dual_port_mem_responder #(
    .DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE), .LAT_I(LI), .LAT_D(LD)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .err(err)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // Reference memory and one outstanding transaction record per port.
  logic [31:0] mm [DEPTH];
  bit          ip = 0, dp = 0, m_err = 0;
  int          i_rc = 0, d_rc = 0;
  logic [31:0] i_a = '0, d_a = '0, d_wd = '0;
  logic [3:0]  i_rm = '0, d_rm = '0, d_wm = '0;

  logic        e_ir, e_dr, e_err;
  logic [31:0] e_ird, e_drd;
  logic        s_ir = 0, s_dr = 0, s_err = 0;
  logic [31:0] s_ird = '0, s_drd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  // Single compare process: outputs against model expectations every cycle.
  always @(negedge clk) begin
    s_ir = imem_resp; s_ird = imem_rdata;
    s_dr = dmem_resp; s_drd = dmem_rdata;
    s_err = err;
    if (chk_en) begin
      chk("model imem_resp",  {31'b0, imem_resp}, {31'b0, e_ir});
      chk("model imem_rdata", imem_rdata, e_ird);
      chk("model dmem_resp",  {31'b0, dmem_resp}, {31'b0, e_dr});
      chk("model dmem_rdata", dmem_rdata, e_drd);
      chk("model err",        {31'b0, err}, {31'b0, e_err});
    end
  end

  // Advance one clock: publish expectations for the current cycle, then fold this
  // cycle's inputs into the model at the closing edge.
  task automatic cycle();
    bit i_idle, d_idle;
    e_ir  = ip && (i_rc == cyc);
    e_ird = e_ir ? (mm[idx_of(i_a)] & lanes(i_rm)) : '0;
    e_dr  = dp && (d_rc == cyc);
    e_drd = (e_dr && d_wm == 4'b0) ? (mm[idx_of(d_a)] & lanes(d_rm)) : '0;
    e_err = m_err;
    @(posedge clk);
    if (!rst) begin
      ip = 0; dp = 0; m_err = 0;
    end else begin
      i_idle = !ip;
      d_idle = !dp;
      if (e_ir) ip = 0;
      if (e_dr) begin
        mm[idx_of(d_a)] = (mm[idx_of(d_a)] & ~lanes(d_wm)) | (d_wd & lanes(d_wm));
        dp = 0;
      end
      if (i_idle && imem_rmask != 0) begin
        ip = 1; i_rc = cyc + LI; i_a = imem_addr; i_rm = imem_rmask;
      end
      if (d_idle && (dmem_rmask != 0 || dmem_wmask != 0)) begin
        dp = 1; d_rc = cyc + LD; d_a = dmem_addr; d_rm = dmem_rmask;
        d_wm = dmem_wmask; d_wd = dmem_wdata;
        if (dmem_rmask != 0 && dmem_wmask != 0) m_err = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic d_txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd);
    int t0;
    t0 = cyc;
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    lat = -1; rd = '0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (s_dr) begin lat = cyc - 1 - t0; rd = s_drd; break; end
    end
    if (lat < 0) chk("d_resp_timeout", {31'b0, s_dr}, 32'd1);
    dmem_rmask = '0; dmem_wmask = '0;
  endtask

  task automatic i_txn(input logic [31:0] a, input logic [3:0] rm,
                       output int lat, output logic [31:0] rd);
    int t0;
    t0 = cyc;
    imem_addr = a; imem_rmask = rm;
    lat = -1; rd = '0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (s_ir) begin lat = cyc - 1 - t0; rd = s_ird; break; end
    end
    if (lat < 0) chk("i_resp_timeout", {31'b0, s_ir}, 32'd1);
    imem_rmask = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 15);
    case ($urandom_range(0, 2))
      0:       return BASE + 32'(4 * k);
      1:       return BASE + 32'(4 * (k + DEPTH)) + 32'($urandom_range(0, 3));
      default: return BASE - 32'(4 * (DEPTH - k));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd;
    bit ih, dh;

    // Reset: establish a known model state, then check reset outputs.
    #1;
    rst = 0;
    cycle();
    chk_en = 1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("rst imem_resp",  {31'b0, s_ir}, 32'd0);
      chk("rst imem_rdata", s_ird, 32'd0);
      chk("rst dmem_resp",  {31'b0, s_dr}, 32'd0);
      chk("rst err",        {31'b0, s_err}, 32'd0);
    end
    rst = 1;

    // Fill the working window (words 0..15) and the directed-test words.
    for (int k = 0; k < 16; k++) d_txn(BASE + 32'(4 * k), 4'h0, 4'hF, $urandom, lat, rd);
    d_txn(BASE,      4'h0, 4'hF, 32'hDEADBEEF, lat, rd);
    d_txn(BASE + 4,  4'h0, 4'hF, 32'hFFFFFFFF, lat, rd);
    d_txn(BASE + 8,  4'h0, 4'hF, 32'hAABBCCDD, lat, rd);
    d_txn(BASE + 12, 4'h0, 4'hF, 32'h00000001, lat, rd);

    // I read latency and data.
    i_txn(BASE, 4'hF, lat, rd);
    chk("i latency", 32'(lat), 32'd2);
    chk("i rdata word0", rd, 32'hDEADBEEF);
    cycle();
    chk("i resp drops after pulse", {31'b0, s_ir}, 32'd0);

    // Partial write, then full read.
    d_txn(BASE + 4, 4'h0, 4'b0011, 32'h1234ABCD, lat, rd);
    chk("d latency", 32'(lat), 32'd3);
    d_txn(BASE + 4, 4'hF, 4'h0, 32'h0, lat, rd);
    chk("d partial write merge", rd, 32'hFFFFABCD);

    // Lane-masked read.
    d_txn(BASE + 8, 4'b0100, 4'h0, 32'h0, lat, rd);
    chk("d lane mask read", rd, 32'h00BB0000);

    // I read and D write to the same word respond in the same cycle.
    dmem_addr = BASE + 12; dmem_rmask = 4'h0; dmem_wmask = 4'hF; dmem_wdata = 32'h2;
    cycle();
    imem_addr = BASE + 12; imem_rmask = 4'hF;
    cycle();
    cycle();
    cycle();
    chk("same-cycle imem_resp", {31'b0, s_ir}, 32'd1);
    chk("same-cycle dmem_resp", {31'b0, s_dr}, 32'd1);
    chk("same-cycle I old data", s_ird, 32'h1);
    imem_rmask = '0; dmem_wmask = '0;
    i_txn(BASE + 12, 4'hF, lat, rd);
    chk("later I new data", rd, 32'h2);
    i_txn(BASE + 12 + 32'(4 * DEPTH) + 32'd3, 4'hF, lat, rd);
    chk("wrapped address", rd, 32'h2);

    // Reset in mid-transaction drops the request.
    dmem_addr = BASE; dmem_rmask = 4'hF; dmem_wmask = 4'h0;
    cycle();
    dmem_rmask = 4'h0;
    rst = 0;
    cycle();
    rst = 1;
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("no resp after reset", {31'b0, s_dr}, 32'd0);
    end
    d_txn(BASE, 4'hF, 4'h0, 32'h0, lat, rd);
    chk("post-reset d latency", 32'(lat), 32'd3);
    chk("post-reset d data", rd, 32'hDEADBEEF);

    // Combined read+write: write lands, data is zero, err sticks.
    d_txn(BASE + 16, 4'hF, 4'hF, 32'hCAFEF00D, lat, rd);
    chk("rw request rdata", rd, 32'h0);
    cycle();
    chk("err set", {31'b0, s_err}, 32'd1);
    d_txn(BASE + 16, 4'hF, 4'h0, 32'h0, lat, rd);
    chk("rw write landed", rd, 32'hCAFEF00D);
    chk("err sticky", {31'b0, s_err}, 32'd1);

    // Randomized traffic on both ports with occasional resets.
    ih = 0; dh = 0;
    for (int n = 0; n < 2000; n++) begin
      if (ih && s_ir) begin ih = 0; imem_rmask = '0; end
      if (dh && s_dr) begin dh = 0; dmem_rmask = '0; dmem_wmask = '0; end
      if (!ih && $urandom_range(0, 2) == 0) begin
        imem_addr = rand_addr();
        imem_rmask = 4'($urandom_range(1, 15));
        ih = 1;
      end else if (!ih) begin
        imem_addr = $urandom;
      end
      if (!dh && $urandom_range(0, 2) == 0) begin
        dmem_addr  = rand_addr();
        dmem_rmask = 4'($urandom_range(0, 15));
        dmem_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        if (dmem_rmask == 0 && dmem_wmask == 0) dmem_rmask = 4'hF;
        dmem_wdata = $urandom;
        dh = 1;
      end
      rst = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst = 1; imem_rmask = '0; dmem_rmask = '0; dmem_wmask = '0;
    for (int n = 0; n < 6; n++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
